// File: rtl/cal_eep_spi_slave_pkg.sv
// Shared definitions for the calibration EEPROM SPI link: frame geometry,
// opcode encoding and the responder FSM state type.
package eep_spi_pkg;

    localparam int         EEP_ADDR_W  = 6;
    localparam int         EEP_DATA_W  = 8;
    localparam int         SPI_FRAME_W = 16;
    localparam logic [2:0] EEP_SS      = 3'b100;

    typedef enum logic [1:0] {
        EEP_RD = 2'b00,
        EEP_WR = 2'b01
    } eep_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } eep_state_t;

    // Opcode field of a frame header selects a memory read.
    function automatic logic op_is_rd(input logic [1:0] op);
        return (op == EEP_RD);
    endfunction

    // Opcode field of a frame header selects a memory write.
    function automatic logic op_is_wr(input logic [1:0] op);
        return (op == EEP_WR);
    endfunction

endpackage

// File: rtl/cal_eep_spi_slave_if.sv
// SPI bus between the command dispatcher (master) and the EEPROM model (slave).
interface cal_eep_spi_slave_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/cal_eep_spi_slave_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin with rise/fall detection
// on the synchronised level. RST_LVL is the idle level of the pin so that
// leaving reset does not fabricate an edge.
module spi_edge_sync #(
    parameter logic RST_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Metastability filter plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_LVL;
            sync_q <= RST_LVL;
            prev_q <= RST_LVL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/cal_eep_spi_slave.sv
// SPI mode-0 responder modelling the scope's calibration EEPROM.
// Frame: {op[1:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}, MSB first.
// Reads return mem[addr] on MISO during the data byte of the same frame;
// writes commit once the full frame has been received.
module cal_eep_spi_slave
    import eep_spi_pkg::*;
#(
    parameter int                ADDR_W  = EEP_ADDR_W,
    parameter int                DATA_W  = EEP_DATA_W,
    parameter int                FRAME_W = SPI_FRAME_W,
    parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cal_eep_spi_slave_if.slave     spi,
    output logic                   frm_done,
    output logic [FRAME_W-1:0]     last_frame,
    output logic                   wr_pulse
);

    localparam int                 CNT_W     = $clog2(FRAME_W + 1);
    localparam int                 DEPTH     = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]   HDR_CNT   = CNT_W'(2 + ADDR_W);
    localparam logic [CNT_W-1:0]   FRAME_CNT = CNT_W'(FRAME_W);

    // Synchronised pins and edges
    logic ss_sync_s, ss_rise_s, ss_fall_s;
    logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
    logic mosi_meta_q, mosi_sync_q;

    // FSM and datapath state
    eep_state_t           state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [FRAME_W-1:0]   rx_shift_q;
    logic [DATA_W-1:0]    tx_shift_q;
    logic                 miso_q;
    logic                 commit_q;
    logic                 frm_done_q;
    logic                 wr_pulse_q;
    logic [FRAME_W-1:0]   last_frame_q;
    logic [DATA_W-1:0]    mem_q [DEPTH];

    // Next-state helpers
    logic [FRAME_W-1:0]   rx_shift_d;
    logic [CNT_W-1:0]     bit_cnt_d;
    logic [1:0]           hdr_op_s;
    logic [DATA_W-1:0]    rd_data_s;
    logic [1:0]           frm_op_s;
    logic [ADDR_W-1:0]    wr_addr_s;
    logic [DATA_W-1:0]    wr_data_s;
    logic                 mem_we_s;

    spi_edge_sync #(.RST_LVL(1'b1)) u_ss_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi.SS_n),
        .sync_o  (ss_sync_s),
        .rise_o  (ss_rise_s),
        .fall_o  (ss_fall_s)
    );

    spi_edge_sync #(.RST_LVL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi.SCLK),
        .sync_o  (sclk_sync_s),
        .rise_o  (sclk_rise_s),
        .fall_o  (sclk_fall_s)
    );

    // MOSI needs only the level, aligned in latency with the synchronised SCLK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= spi.MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Shift-in value, header decode (read data looked up from the header being completed) and write-commit fields.
    always_comb begin
        rx_shift_d = {rx_shift_q[FRAME_W-2:0], mosi_sync_q};
        bit_cnt_d  = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        hdr_op_s   = rx_shift_d[ADDR_W+1:ADDR_W];
        rd_data_s  = mem_q[rx_shift_d[ADDR_W-1:0]];
        frm_op_s   = rx_shift_q[FRAME_W-1:FRAME_W-2];
        wr_addr_s  = rx_shift_q[DATA_W+ADDR_W-1:DATA_W];
        wr_data_s  = rx_shift_q[DATA_W-1:0];
        if ((state_q == ST_DONE) && commit_q && op_is_wr(frm_op_s)) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Frame FSM: track SS_n, shift on SCLK edges, commit once per received frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            miso_q       <= 1'b0;
            commit_q     <= 1'b0;
            frm_done_q   <= 1'b0;
            wr_pulse_q   <= 1'b0;
            last_frame_q <= '0;
        end else begin
            frm_done_q <= 1'b0;
            wr_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    miso_q <= 1'b0;
                    if (ss_fall_s) begin
                        state_q    <= ST_SHIFT;
                        bit_cnt_q  <= '0;
                        rx_shift_q <= '0;
                        tx_shift_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (ss_sync_s) begin
                        // Aborted frame: drop it without side effects.
                        state_q <= ST_IDLE;
                        miso_q  <= 1'b0;
                    end else if (sclk_rise_s) begin
                        rx_shift_q <= rx_shift_d;
                        bit_cnt_q  <= bit_cnt_d;
                        if (bit_cnt_d == HDR_CNT) begin
                            tx_shift_q <= op_is_rd(hdr_op_s) ? rd_data_s : {DATA_W{1'b0}};
                        end
                        if (bit_cnt_d == FRAME_CNT) begin
                            state_q  <= ST_DONE;
                            commit_q <= 1'b1;
                            miso_q   <= 1'b0;
                        end
                    end else if (sclk_fall_s) begin
                        miso_q     <= tx_shift_q[DATA_W-1];
                        tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    // Extra SCLK edges are ignored here until SS_n returns high.
                    miso_q <= 1'b0;
                    if (commit_q) begin
                        commit_q     <= 1'b0;
                        frm_done_q   <= 1'b1;
                        last_frame_q <= rx_shift_q;
                        wr_pulse_q   <= op_is_wr(frm_op_s);
                    end
                    if (ss_sync_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    miso_q   <= 1'b0;
                    commit_q <= 1'b0;
                end
            endcase
        end
    end

    // Register-array memory: reinitialised on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (mem_we_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    assign spi.MISO  = miso_q & ~ss_sync_s;
    assign frm_done  = frm_done_q;
    assign wr_pulse  = wr_pulse_q;
    assign last_frame = last_frame_q;

endmodule
